// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl
// ---------------------------------------------------------------------------
// Frame-level controller for the serial "1101" Mealy detector.
// Parallel words are accepted over a valid/ready handshake into a one-entry
// holding buffer. Each word is then serialized MSB-first into the detector,
// one bit per clock. Consecutive words of a frame are sent with no gap, and
// the detector keeps its state across word boundaries. Detector hits are
// counted per frame. Between frames the detector is held in reset. At the
// end of a frame a one-cycle done pulse reports the count, the saturation
// flag and the underrun status.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   CNT_W      match counter width
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream word valid
//   in_ready   holding buffer empty, a word can be accepted
//   in_data    word to scan, bit WIDTH-1 is sent first
//   in_last    in_data is the final word of its frame
//   det_rst    detector reset (registered)
//   det_in     detector serial input (registered)
//   det_f      detector Mealy output, sampled only while shifting
//   done       one-cycle end-of-frame pulse
//   err        underrun flag, meaningful only while done=1
//   match_cnt  match count of the current or last frame
//   overflow   sticky counter saturation flag of the current or last frame
// ---------------------------------------------------------------------------
module seq_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             det_rst,
  output logic             det_in,
  input  logic             det_f,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] match_cnt,
  output logic             overflow
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_e;

  // Control state
  state_e           state_q, state_d;
  logic             hold_valid_q, hold_valid_d;
  logic             cur_last_q, cur_last_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;

  // Registered outputs
  logic             det_rst_q, det_rst_d;
  logic             det_in_q, det_in_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             overflow_q, overflow_d;

  // Datapath
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             hold_last_q, hold_last_d;
  // Bits of the current word still to be sent after the one in det_in_q.
  logic [WIDTH-2:0] shreg_q, shreg_d;

  logic             accept;
  logic             pop;

  assign in_ready = !hold_valid_q;
  assign accept   = in_valid && !hold_valid_q;

  // NOTE: every signal written here is given a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    shreg_d      = shreg_q;
    cur_last_d   = cur_last_q;
    bit_idx_d    = bit_idx_q;
    det_rst_d    = 1'b1;
    det_in_d     = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    match_cnt_d  = match_cnt_q;
    overflow_d   = overflow_q;
    pop          = 1'b0;

    // accept and pop are mutually exclusive: accept needs an empty buffer,
    // pop needs a full one.
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_data_d  = in_data;
      hold_last_d  = in_last;
    end

    unique case (state_q)
      IDLE: begin
        if (hold_valid_q) begin
          pop         = 1'b1;
          match_cnt_d = '0;
          overflow_d  = 1'b0;
        end
      end

      SHIFT: begin
        // det_f reflects the bit currently on det_in.
        if (det_f) begin
          if (&match_cnt_q) overflow_d = 1'b1;
          else              match_cnt_d = match_cnt_q + CNT_W'(1);
        end

        if (bit_idx_q != '0) begin
          det_rst_d = 1'b0;
          det_in_d  = shreg_q[WIDTH-2];
          shreg_d   = shreg_q << 1;
          bit_idx_d = bit_idx_q - IDX_W'(1);
        end else if (cur_last_q) begin
          state_d = REPORT;
          done_d  = 1'b1;
        end else if (hold_valid_q) begin
          // Seamless continuation; detector stays out of reset.
          pop = 1'b1;
        end else begin
          state_d = REPORT;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end

      REPORT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Move the buffered word into the shifter: its MSB goes straight to
    // det_in, the rest waits in shreg.
    if (pop) begin
      state_d      = SHIFT;
      hold_valid_d = 1'b0;
      det_rst_d    = 1'b0;
      det_in_d     = hold_data_q[WIDTH-1];
      shreg_d      = hold_data_q[WIDTH-2:0];
      cur_last_d   = hold_last_q;
      bit_idx_d    = LAST_IDX;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_valid_q <= 1'b0;
      cur_last_q   <= 1'b0;
      bit_idx_q    <= '0;
      det_rst_q    <= 1'b1;
      det_in_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      match_cnt_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      cur_last_q   <= cur_last_d;
      bit_idx_q    <= bit_idx_d;
      det_rst_q    <= det_rst_d;
      det_in_q     <= det_in_d;
      done_q       <= done_d;
      err_q        <= err_d;
      match_cnt_q  <= match_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  // NOTE: payload registers carry no reset; they are only consumed when the
  // matching valid/state flop says so, and those flops are reset.
  always_ff @(posedge clk) begin
    hold_data_q <= hold_data_d;
    hold_last_q <= hold_last_d;
    shreg_q     <= shreg_d;
  end

  assign det_rst   = det_rst_q;
  assign det_in    = det_in_q;
  assign done      = done_q;
  assign err       = err_q;
  assign match_cnt = match_cnt_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl
// ---------------------------------------------------------------------------
// Bench for seq_scan_ctrl. Two instances share one input stream:
//   index 0: CNT_W=8
//   index 1: CNT_W=2, so saturation is exercised.
// Each instance drives its own behavioural "1101" non-overlapping Mealy
// detector. Expected frame results come from scanning the frame's bit
// sequence directly.
// ---------------------------------------------------------------------------
module tb_seq_scan_ctrl;

  localparam int WIDTH = 8;

  typedef struct {
    int cnt;
    bit err;
    int nwords;
  } frame_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;

  logic             in_ready_v [2];
  logic             det_rst_v  [2];
  logic             det_in_v   [2];
  logic             det_f_v    [2];
  logic             done_v     [2];
  logic             err_v      [2];
  logic             ov_v       [2];
  logic [7:0]       cnt_v      [2];
  logic [7:0]       match_cnt_w;
  logic [1:0]       match_cnt_s;
  logic [1:0]       det_st     [2];

  int     n_vec = 0;
  int     n_err = 0;
  int     edge_cnt = 0;
  int     last_acc_edge = 0;
  int     last_done_edge [2] = '{0, 0};
  frame_t exp_q[$];
  int     rd_ptr   [2] = '{0, 0};
  int     low_cnt  [2] = '{0, 0};
  int     held_cnt [2] = '{0, 0};
  bit     held_ov  [2] = '{1'b0, 1'b0};
  bit     prev_drst[2] = '{1'b1, 1'b1};
  logic   rst_q = 1'b1;
  frame_t e;
  int     maxv;

  always #5 clk = ~clk;

  seq_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(8)) u_dut_w (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .in_data(in_data), .in_last(in_last),
    .det_rst(det_rst_v[0]), .det_in(det_in_v[0]), .det_f(det_f_v[0]),
    .done(done_v[0]), .err(err_v[0]),
    .match_cnt(match_cnt_w), .overflow(ov_v[0])
  );

  seq_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(2)) u_dut_s (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .in_data(in_data), .in_last(in_last),
    .det_rst(det_rst_v[1]), .det_in(det_in_v[1]), .det_f(det_f_v[1]),
    .done(done_v[1]), .err(err_v[1]),
    .match_cnt(match_cnt_s), .overflow(ov_v[1])
  );

  assign cnt_v[0] = match_cnt_w;
  assign cnt_v[1] = {6'b0, match_cnt_s};

  // Non-overlapping "1101" Mealy detector.
  // States:
  //   0 = nothing seen
  //   1 = "1"
  //   2 = "11"
  //   3 = "110"
  function automatic logic [1:0] det_next(input logic [1:0] s, input logic b);
    case (s)
      2'd0:    return b ? 2'd1 : 2'd0;
      2'd1:    return b ? 2'd2 : 2'd0;
      2'd2:    return b ? 2'd2 : 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  assign det_f_v[0] = (det_st[0] == 2'd3) && det_in_v[0];
  assign det_f_v[1] = (det_st[1] == 2'd3) && det_in_v[1];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      det_st[k] <= det_rst_v[k] ? 2'd0 : det_next(det_st[k], det_in_v[k]);
    edge_cnt <= edge_cnt + 1;
    rst_q    <= rst;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: greedy left-to-right scan for non-overlapping "1101".
  function automatic int count_1101(input bit bits[$]);
    int n = 0;
    int i = 0;
    while (i + 3 < bits.size()) begin
      if (bits[i] && bits[i+1] && !bits[i+2] && bits[i+3]) begin
        n++;
        i += 4;
      end else begin
        i++;
      end
    end
    return n;
  endfunction

  // Per-cycle monitor, sampled on the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_q) begin
        low_cnt[k]   = 0;
        held_cnt[k]  = 0;
        held_ov[k]   = 1'b0;
        prev_drst[k] = 1'b1;
      end else begin
        if (!det_rst_v[k]) begin
          if (prev_drst[k]) begin
            check($sformatf("start_cnt%0d", k), cnt_v[k], 0);
            check($sformatf("start_ov%0d", k), ov_v[k], 0);
          end
          low_cnt[k]++;
        end else begin
          check($sformatf("idle_det_in%0d", k), det_in_v[k], 0);
          if (done_v[k]) begin
            last_done_edge[k] = edge_cnt;
            if (rd_ptr[k] >= exp_q.size()) begin
              check($sformatf("spurious_done%0d", k), rd_ptr[k], exp_q.size());
            end else begin
              e    = exp_q[rd_ptr[k]];
              maxv = (k == 0) ? 255 : 3;
              check($sformatf("cnt%0d", k), cnt_v[k], (e.cnt > maxv) ? maxv : e.cnt);
              check($sformatf("ov%0d", k), ov_v[k], e.cnt > maxv);
              check($sformatf("err%0d", k), err_v[k], e.err);
              check($sformatf("shift_cycles%0d", k), low_cnt[k], e.nwords * WIDTH);
              held_cnt[k] = (e.cnt > maxv) ? maxv : e.cnt;
              held_ov[k]  = e.cnt > maxv;
              rd_ptr[k]++;
            end
            low_cnt[k] = 0;
          end else begin
            check($sformatf("hold_cnt%0d", k), cnt_v[k], held_cnt[k]);
            check($sformatf("hold_ov%0d", k), ov_v[k], held_ov[k]);
          end
        end
        prev_drst[k] = det_rst_v[k];
      end
    end
  end

  task automatic send_word(input logic [WIDTH-1:0] d, input logic l);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready_v[0] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready_v[0]) begin
      check("accept_timeout", in_ready_v[0], 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    last_acc_edge = edge_cnt;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((rd_ptr[0] != exp_q.size() || rd_ptr[1] != exp_q.size()) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain0", rd_ptr[0], exp_q.size());
    check("drain1", rd_ptr[1], exp_q.size());
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] words[$], input bit underrun);
    bit     bits[$];
    frame_t f;
    foreach (words[i])
      for (int b = WIDTH - 1; b >= 0; b--)
        bits.push_back(words[i][b]);
    f.cnt    = count_1101(bits);
    f.err    = underrun;
    f.nwords = words.size();
    exp_q.push_back(f);
    foreach (words[i])
      send_word(words[i], !underrun && (i == words.size() - 1));
    // An underrun only happens if nothing else arrives, so wait it out.
    if (underrun) wait_drain();
  endtask

  function automatic logic [WIDTH-1:0] rand_word();
    logic [WIDTH-1:0] tbl [7];
    int r;
    tbl = '{8'hDA, 8'hDD, 8'hDB, 8'h0D, 8'hB0, 8'h03, 8'h40};
    r = $urandom_range(0, 7);
    if (r == 7) return WIDTH'($urandom);
    return tbl[r];
  endfunction

  logic [WIDTH-1:0] wq[$];
  int nw;
  bit ur;

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_det_rst%0d", k), det_rst_v[k], 1);
      check($sformatf("rst_det_in%0d", k), det_in_v[k], 0);
      check($sformatf("rst_done%0d", k), done_v[k], 0);
      check($sformatf("rst_cnt%0d", k), cnt_v[k], 0);
      check($sformatf("rst_ov%0d", k), ov_v[k], 0);
      check($sformatf("rst_ready%0d", k), in_ready_v[k], 1);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single word, latency from acceptance to done
    wq = {8'hDA};
    send_frame(wq, 1'b0);
    wait_drain();
    check("done_latency", last_done_edge[0] - last_acc_edge, WIDTH + 1);

    // Match spanning a word boundary
    wq = {8'h03, 8'h40};
    send_frame(wq, 1'b0);
    wait_drain();

    // Two matches; then no overlap
    wq = {8'hDD};
    send_frame(wq, 1'b0);
    wq = {8'hDB};
    send_frame(wq, 1'b0);
    wait_drain();

    // Underrun
    wq = {8'h03};
    send_frame(wq, 1'b1);

    // Saturation of the narrow counter, then clear on the next frame
    wq = {8'hDD, 8'hDD, 8'hDD, 8'hDD};
    send_frame(wq, 1'b0);
    wait_drain();
    repeat (3) @(negedge clk);
    wq = {8'h0D};
    send_frame(wq, 1'b0);
    wait_drain();

    // Reset mid-frame with the holding buffer full
    send_word(8'h03, 1'b0);
    send_word(8'h40, 1'b1);
    repeat (2) @(negedge clk);
    check("hold_full", in_ready_v[0], 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("abort_ready%0d", k), in_ready_v[k], 1);
      check($sformatf("abort_det_rst%0d", k), det_rst_v[k], 1);
      check($sformatf("abort_cnt%0d", k), cnt_v[k], 0);
      check($sformatf("abort_done%0d", k), done_v[k], 0);
    end
    repeat (20) @(negedge clk);
    wq = {8'hDA};
    send_frame(wq, 1'b0);
    wait_drain();

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      nw = $urandom_range(1, 4);
      ur = ($urandom_range(0, 5) == 0);
      wq = {};
      for (int i = 0; i < nw; i++) wq.push_back(rand_word());
      send_frame(wq, ur);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain();
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
